// File: rtl/result_stream_rx.sv
// result_stream_rx: receive side of the matrix-multiplier result byte stream.
// Rebuilds the N x N result matrix (W-bit entries, LSB byte first) into c_flat
// and raises frame_done once every entry of a frame has been captured.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no frame in progress; the next valid byte is byte 0 of entry 0
// RECV  | frame in progress; idle counter guards against a stalled sender
// FULL  | frame captured; further bytes are overruns until clear/reset
module result_stream_rx #(
  parameter int N       = 3,
  parameter int W       = 18,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  input  logic               clear,
  output logic [N*N*W-1:0]   c_flat,
  output logic               frame_done,
  output logic               done_pulse,
  output logic [7:0]         byte_count,
  output logic               err_timeout,
  output logic               err_overrun
);

  localparam int BPE = (W + 7) / 8;
  localparam int NE  = N * N;
  localparam int BW  = (BPE > 1) ? $clog2(BPE) : 1;
  localparam int EW  = (NE > 1) ? $clog2(NE) : 1;

  localparam logic [BW-1:0] LAST_BYTE  = BW'(BPE - 1);
  localparam logic [EW-1:0] LAST_ENTRY = EW'(NE - 1);
  // Timeout fires on the idle cycle that would bring the counter to TIMEOUT.
  localparam logic [7:0]    IDLE_LAST  = 8'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  logic [1:0]       state;
  logic [BW-1:0]    byte_idx;
  logic [EW-1:0]    entry_idx;
  logic [8*BPE-1:0] shreg;
  logic [8*BPE-1:0] asm_word;
  logic [7:0]       idle_cnt;

  // Merge the incoming byte into the partially assembled entry.
  always_comb begin
    asm_word = shreg;
    for (int b = 0; b < BPE; b++) begin
      if (byte_idx == b[BW-1:0]) begin
        asm_word[b*8 +: 8] = in_data;
      end
    end
  end

  // Frame FSM, assembly, counters and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      byte_idx    <= '0;
      entry_idx   <= '0;
      shreg       <= '0;
      idle_cnt    <= '0;
      c_flat      <= '0;
      frame_done  <= 1'b0;
      done_pulse  <= 1'b0;
      byte_count  <= '0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else if (clear) begin
      // Re-arm only; captured data stays visible to the host.
      state       <= S_IDLE;
      byte_idx    <= '0;
      entry_idx   <= '0;
      shreg       <= '0;
      idle_cnt    <= '0;
      frame_done  <= 1'b0;
      done_pulse  <= 1'b0;
      byte_count  <= '0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      case (state)
        S_IDLE, S_RECV: begin
          if (in_valid) begin
            idle_cnt <= '0;
            shreg    <= asm_word;
            if (byte_count != 8'hFF) begin
              byte_count <= byte_count + 8'd1;
            end
            if (byte_idx == LAST_BYTE) begin
              byte_idx <= '0;
              for (int k = 0; k < NE; k++) begin
                if (entry_idx == k[EW-1:0]) begin
                  c_flat[k*W +: W] <= asm_word[W-1:0];
                end
              end
              if (entry_idx == LAST_ENTRY) begin
                entry_idx  <= '0;
                state      <= S_FULL;
                frame_done <= 1'b1;
                done_pulse <= 1'b1;
              end else begin
                entry_idx <= entry_idx + 1'b1;
                state     <= S_RECV;
              end
            end else begin
              byte_idx <= byte_idx + 1'b1;
              state    <= S_RECV;
            end
          end else if (state == S_RECV) begin
            if (idle_cnt == IDLE_LAST) begin
              state       <= S_IDLE;
              byte_idx    <= '0;
              entry_idx   <= '0;
              idle_cnt    <= '0;
              byte_count  <= '0;
              err_timeout <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + 8'd1;
            end
          end
        end
        S_FULL: begin
          if (in_valid) begin
            err_overrun <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
